dmem_loader: RTL and testbench

- Sits directly upstream of the single-cycle CPU's word-addressed data memory, between the CPU's memory-access signals and the memory's r_address/w_data/MemWrite/MemRead inputs.
- After reset it holds the CPU, accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them to consecutive memory words starting at 0.
- When loading finishes it releases the CPU and passes the CPU's memory signals straight through to the memory.

---
 rtl/dmem_loader.sv | 136 +++++++++++++
 tb/tb_dmem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_loader.sv
// dmem_loader: boot-time loader in front of the single-cycle CPU's data memory.
// After reset it stalls the CPU, assembles little-endian bytes into 32-bit
// words, writes them to memory words 0..LOAD_WORDS-1, then hands the memory
// port back to the CPU as a zero-latency combinational pass-through.
module dmem_loader #(
   parameter int LOAD_WORDS = 32,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              bypass,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic              cpu_memwrite,
   input  logic              cpu_memread,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_memwrite,
   output logic              mem_memread,
   output logic              cpu_hold,
   output logic              load_done,
   output logic [ADDR_W-1:0] word_count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ASSEMBLE = 2'd1,
      S_WRITE    = 2'd2,
      S_RUN      = 2'd3
   } state_t;

   // Pointer value of the final word of a load.
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_buf_q, word_buf_d;
   logic              load_done_q, load_done_d;

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         word_ptr_q  <= '0;
         byte_idx_q  <= '0;
         word_buf_q  <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_ptr_q  <= word_ptr_d;
         byte_idx_q  <= byte_idx_d;
         word_buf_q  <= word_buf_d;
         load_done_q <= load_done_d;
      end
   end

   // Next-state logic: byte assembly, word pointer advance, completion pulse.
   always_comb begin
      state_d     = state_q;
      word_ptr_d  = word_ptr_q;
      byte_idx_d  = byte_idx_q;
      word_buf_d  = word_buf_q;
      load_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            // start wins over bypass
            if (start) begin
               state_d    = S_ASSEMBLE;
               word_ptr_d = '0;
               byte_idx_d = '0;
            end else if (bypass) begin
               state_d = S_RUN;
            end
         end
         S_ASSEMBLE: begin
            // in_ready is 1 here, so in_valid alone marks an accepted byte
            if (in_valid) begin
               word_buf_d[8*byte_idx_q +: 8] = in_byte;
               byte_idx_d                    = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (word_ptr_q == LAST_PTR) begin
               word_ptr_d  = '0;
               state_d     = S_RUN;
               load_done_d = 1'b1;
            end else begin
               word_ptr_d = word_ptr_q + 1'b1;
               state_d    = S_ASSEMBLE;
            end
         end
         S_RUN: begin
            if (start) begin
               state_d    = S_ASSEMBLE;
               word_ptr_d = '0;
               byte_idx_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output mux: loader drives memory from registers, RUN passes CPU straight through.
   always_comb begin
      cpu_hold     = 1'b1;
      in_ready     = 1'b0;
      mem_addr     = 32'(word_ptr_q);
      mem_wdata    = word_buf_q;
      mem_memwrite = 1'b0;
      mem_memread  = 1'b0;
      case (state_q)
         S_ASSEMBLE: in_ready = 1'b1;
         S_WRITE:    mem_memwrite = 1'b1;
         S_RUN: begin
            cpu_hold     = 1'b0;
            mem_addr     = cpu_addr;
            mem_wdata    = cpu_wdata;
            mem_memwrite = cpu_memwrite;
            mem_memread  = cpu_memread;
         end
         default: ;
      endcase
   end

   assign load_done  = load_done_q;
   assign word_count = word_ptr_q;

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: directed bench for dmem_loader with LOAD_WORDS=1 and 32,
// backed by a behavioural 32-word memory on the LOAD_WORDS=32 instance.
module tb_dmem_loader;

   logic        clk;
   logic        reset, start, bypass, in_valid;
   logic [7:0]  in_byte;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_memwrite, cpu_memread;

   logic        a_in_ready, a_mw, a_mr, a_hold, a_done;
   logic [31:0] a_addr, a_wdata;
   logic [4:0]  a_wc;
   logic        b_in_ready, b_mw, b_mr, b_hold, b_done;
   logic [31:0] b_addr, b_wdata;
   logic [4:0]  b_wc;

   logic [31:0] mem [0:31];
   logic [31:0] rdata;
   int          wr_a, wr_b;
   int          checks, errors;

   dmem_loader #(.LOAD_WORDS(1), .ADDR_W(5)) dut1 (
      .clk(clk), .reset(reset), .start(start), .bypass(bypass),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(a_in_ready),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
      .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_memwrite(a_mw),
      .mem_memread(a_mr), .cpu_hold(a_hold), .load_done(a_done),
      .word_count(a_wc));

   dmem_loader #(.LOAD_WORDS(32), .ADDR_W(5)) dut32 (
      .clk(clk), .reset(reset), .start(start), .bypass(bypass),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(b_in_ready),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
      .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_memwrite(b_mw),
      .mem_memread(b_mr), .cpu_hold(b_hold), .load_done(b_done),
      .word_count(b_wc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-addressed data memory fed by the 32-word loader.
   always @(posedge clk) begin
      if (b_mw) mem[b_addr[4:0]] <= b_wdata;
   end
   assign rdata = mem[b_addr[4:0]];

   // Write-cycle counters, cleared by reset.
   always @(posedge clk) begin
      if (reset) begin
         wr_a <= 0;
         wr_b <= 0;
      end else begin
         if (a_mw) wr_a <= wr_a + 1;
         if (b_mw) wr_b <= wr_b + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_byte  = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic feed_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) feed_byte(w[8*i +: 8]);
   endtask

   initial begin
      int          b;
      int          cyc;
      bit          acc;
      logic [31:0] exp;

      checks = 0; errors = 0;
      reset = 1'b1; start = 1'b0; bypass = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
      cpu_addr = '0; cpu_wdata = '0; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
      for (int k = 0; k < 32; k++) mem[k] = 32'hA5A5_0000 + k;
      step(); step();
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_hold", a_hold, 1);
      chk("rst_ready", a_in_ready, 0);
      chk("rst_mw", a_mw, 0);
      chk("rst_mr", a_mr, 0);
      chk("rst_addr", a_addr, 0);
      chk("rst_wdata", a_wdata, 0);
      chk("rst_done", a_done, 0);
      chk("rst_wc", a_wc, 0);

      // Single-word load (LOAD_WORDS=1)
      step();
      start = 1'b1; step(); start = 1'b0;
      @(negedge clk);
      chk("w1_ready", a_in_ready, 1);
      feed_word(32'h0000_000B);
      @(negedge clk);
      chk("w1_mw", a_mw, 1);
      chk("w1_addr", a_addr, 0);
      chk("w1_wdata", a_wdata, 32'h0000_000B);
      chk("w1_hold_wr", a_hold, 1);
      chk("w1_ready_wr", a_in_ready, 0);
      step();
      @(negedge clk);
      chk("w1_done", a_done, 1);
      chk("w1_hold_run", a_hold, 0);
      chk("w1_mw_run", a_mw, 0);
      step();
      @(negedge clk);
      chk("w1_done_clr", a_done, 0);
      chk("w1_writes", wr_a, 1);

      // Full 32-word load with stalls; CPU writes to word 5 must be ignored
      reset = 1'b1; step(); reset = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      cpu_memwrite = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hFFFF_FFFF;
      b = 0;
      cyc = 0;
      while (b < 128 && cyc < 3000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_byte  = 8'(b);
         @(negedge clk);
         if (cyc == 0) chk("asm_cpu_mw_blocked", b_mw, 0);
         acc = in_valid && b_in_ready;
         step();
         if (acc) b++;
         cyc++;
      end
      in_valid = 1'b0;
      cpu_memwrite = 1'b0;
      chk("stream_done", b, 128);
      @(negedge clk);
      chk("w32_last_mw", b_mw, 1);
      chk("w32_last_addr", b_addr, 31);
      chk("w32_last_wdata", b_wdata, 32'h7F7E_7D7C);
      chk("w32_last_wc", b_wc, 31);
      step();
      @(negedge clk);
      chk("w32_done", b_done, 1);
      chk("w32_hold", b_hold, 0);
      chk("w32_wc_wrap", b_wc, 0);
      chk("w32_writes", wr_b, 32);
      for (int k = 0; k < 32; k++) begin
         exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
         chk($sformatf("mem%0d", k), mem[k], exp);
      end

      // RUN pass-through
      cpu_addr = 32'd2; cpu_memread = 1'b1; cpu_memwrite = 1'b0;
      @(negedge clk);
      chk("run_addr2", b_addr, 2);
      chk("run_mr", b_mr, 1);
      chk("run_mw0", b_mw, 0);
      chk("run_rd2", rdata, 32'h0B0A_0908);
      step();
      cpu_addr = 32'd3; cpu_wdata = 32'hDEAD_BEEF; cpu_memwrite = 1'b1; cpu_memread = 1'b0;
      @(negedge clk);
      chk("run_addr3", b_addr, 3);
      chk("run_wdata", b_wdata, 32'hDEAD_BEEF);
      chk("run_mw1", b_mw, 1);
      chk("run_mr0", b_mr, 0);
      step();
      cpu_memwrite = 1'b0; cpu_memread = 1'b1;
      @(negedge clk);
      chk("run_rd3", rdata, 32'hDEAD_BEEF);
      step();
      cpu_memread = 1'b0; cpu_addr = '0; cpu_wdata = '0;

      // Reload from RUN, then reset after two bytes of word 4
      start = 1'b1; step(); start = 1'b0;
      @(negedge clk);
      chk("rl_hold", b_hold, 1);
      chk("rl_ready", b_in_ready, 1);
      chk("rl_wc", b_wc, 0);
      for (int k = 0; k < 4; k++) begin
         feed_word(32'hC000_0000 + k);
         step();
      end
      feed_byte(8'hEE); feed_byte(8'hEF);
      reset = 1'b1; step(); reset = 1'b0;
      @(negedge clk);
      chk("mr_wc", b_wc, 0);
      chk("mr_ready", b_in_ready, 0);
      chk("mr_hold", b_hold, 1);
      chk("mr_mem3", mem[3], 32'hC000_0003);
      chk("mr_mem4", mem[4], 32'h1312_1110);
      start = 1'b1; step(); start = 1'b0;
      feed_word(32'h4433_2211);
      @(negedge clk);
      chk("mr_mw", b_mw, 1);
      chk("mr_addr", b_addr, 0);
      chk("mr_wdata", b_wdata, 32'h4433_2211);
      step();

      // Bypass, then reload from RUN
      reset = 1'b1; step(); reset = 1'b0;
      bypass = 1'b1;
      @(negedge clk);
      chk("bp_idle_hold", b_hold, 1);
      step(); bypass = 1'b0;
      @(negedge clk);
      chk("bp_hold", b_hold, 0);
      chk("bp_done", b_done, 0);
      chk("bp_ready", b_in_ready, 0);
      start = 1'b1; step(); start = 1'b0;
      @(negedge clk);
      chk("bp_rl_hold", b_hold, 1);
      chk("bp_rl_wc", b_wc, 0);
      chk("bp_rl_ready", b_in_ready, 1);
      feed_word(32'h8877_6655);
      @(negedge clk);
      chk("bp_rl_mw", b_mw, 1);
      chk("bp_rl_addr", b_addr, 0);
      chk("bp_rl_wdata", b_wdata, 32'h8877_6655);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
